// File: rtl/clk_tick_pkg.sv
// Shared types and constants for the clk_tick_gen divider/counter block.
package clk_tick_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A divide ratio of zero is treated as divide-by-one.
  localparam int unsigned ZERO_DIV_SUB = 1;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts enabled cycles and flags the terminal count div-1.
module tick_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             term
);

  logic [DIV_W-1:0] cnt_r;

  assign term = en && (cnt_r == (div - DIV_W'(1)));

  // Prescaler counter: cleared on run start, wraps to zero at the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (term) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + DIV_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/clk_tick_gen.sv
// Divides clk into a one-cycle tick strobe and counts ticks under a start/stop handshake.
module clk_tick_gen
  import clk_tick_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int CNT_W     = 16,
  parameter bit AUTO_STOP = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div_val,
  input  logic [CNT_W-1:0] limit,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             busy,
  output logic             done,
  output logic             wrapped
);

  state_t           state_r;
  logic [DIV_W-1:0] div_r;
  logic [CNT_W-1:0] limit_r;
  logic             accept_s;
  logic             run_s;
  logic             term_s;
  logic             auto_hit_s;
  logic [CNT_W-1:0] next_count_s;

  assign accept_s     = (state_r == IDLE) && start;
  assign run_s        = (state_r == RUN);
  assign next_count_s = tick_count + CNT_W'(1);
  // The compare uses the post-increment value, so a wrap to zero satisfies limit=0.
  assign auto_hit_s   = AUTO_STOP && term_s && (next_count_s == limit_r);

  tick_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept_s),
    .en   (run_s),
    .div  (div_r),
    .term (term_s)
  );

  // Run-control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      div_r      <= DIV_W'(ZERO_DIV_SUB);
      limit_r    <= '0;
      tick       <= 1'b0;
      tick_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wrapped    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          tick <= 1'b0;
          done <= 1'b0;
          if (start) begin
            div_r      <= (div_val == '0) ? DIV_W'(ZERO_DIV_SUB) : div_val;
            limit_r    <= limit;
            tick_count <= '0;
            wrapped    <= 1'b0;
            busy       <= 1'b1;
            state_r    <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          tick <= term_s;
          busy <= 1'b1;
          if (term_s) begin
            tick_count <= next_count_s;
            if (&tick_count) begin
              wrapped <= 1'b1;
            end else begin
              wrapped <= wrapped;
            end
          end else begin
            tick_count <= tick_count;
          end
          // A terminal count coinciding with the stop is still issued and counted.
          if (stop || auto_hit_s) begin
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            done    <= 1'b0;
            state_r <= RUN;
          end
        end
        DONE: begin
          tick    <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          tick    <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Directed self-checking bench for clk_tick_gen: default instance plus an AUTO_STOP/CNT_W=4 instance.
module tb_clk_tick_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  div_val;
  logic        start_a, stop_a, start_b, stop_b;
  logic [15:0] limit_a;
  logic [3:0]  limit_b;
  logic        tick_a, busy_a, done_a, wrap_a;
  logic [15:0] cnt_a;
  logic        tick_b, busy_b, done_b, wrap_b;
  logic [3:0]  cnt_b;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  clk_tick_gen dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a),
    .div_val(div_val), .limit(limit_a),
    .tick(tick_a), .tick_count(cnt_a), .busy(busy_a), .done(done_a), .wrapped(wrap_a)
  );

  clk_tick_gen #(.DIV_W(8), .CNT_W(4), .AUTO_STOP(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b),
    .div_val(div_val), .limit(limit_b),
    .tick(tick_b), .tick_count(cnt_b), .busy(busy_b), .done(done_b), .wrapped(wrap_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_idle(input string tag, input int exp_cnt);
    check_val({tag, " tick"}, 32'(tick_a), 32'd0);
    check_val({tag, " busy"}, 32'(busy_a), 32'd0);
    check_val({tag, " done"}, 32'(done_a), 32'd0);
    check_val({tag, " cnt"},  32'(cnt_a), exp_cnt);
  endtask

  // One run on instance A: start sampled at E0, stop sampled at edge n_stop.
  task automatic run_a(input int dv, input int n_stop, input int exp_final,
                       input bit hold, input bit stop_too);
    int d;
    int cnt;
    d = (dv == 0) ? 1 : dv;
    cnt = 0;
    div_val = 8'(dv);
    start_a = 1'b1;
    stop_a  = stop_too;
    cyc();
    check_val($sformatf("d%0d start busy", dv), 32'(busy_a), 32'd1);
    check_val($sformatf("d%0d start cnt", dv),  32'(cnt_a), 32'd0);
    check_val($sformatf("d%0d start tick", dv), 32'(tick_a), 32'd0);
    start_a = hold;
    stop_a  = 1'b0;
    div_val = 8'd7;
    for (int k = 1; k <= n_stop; k++) begin
      if (k == n_stop) stop_a = 1'b1;
      cyc();
      if (k % d == 0) cnt++;
      check_val($sformatf("d%0d k%0d tick", dv, k), 32'(tick_a), 32'(k % d == 0));
      check_val($sformatf("d%0d k%0d cnt", dv, k),  32'(cnt_a), cnt);
      check_val($sformatf("d%0d k%0d done", dv, k), 32'(done_a), 32'(k == n_stop));
      check_val($sformatf("d%0d k%0d busy", dv, k), 32'(busy_a), 32'd1);
    end
    stop_a = 1'b0;
    check_val($sformatf("d%0d final cnt", dv), 32'(cnt_a), exp_final);
    cyc();
    check_a_idle($sformatf("d%0d after", dv), exp_final);
  endtask

  // One auto-stop run on instance B with div=1: done expected at edge n_done.
  task automatic run_b(input int lim, input int n_done, input int exp_wrap);
    div_val = 8'd1;
    limit_b = 4'(lim);
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    check_val($sformatf("b l%0d start busy", lim), 32'(busy_b), 32'd1);
    for (int k = 1; k <= n_done; k++) begin
      cyc();
      check_val($sformatf("b l%0d k%0d cnt", lim, k),  32'(cnt_b), 32'(k % 16));
      check_val($sformatf("b l%0d k%0d done", lim, k), 32'(done_b), 32'(k == n_done));
      check_val($sformatf("b l%0d k%0d wrap", lim, k), 32'(wrap_b), 32'(k >= 16));
      check_val($sformatf("b l%0d k%0d tick", lim, k), 32'(tick_b), 32'd1);
    end
    check_val($sformatf("b l%0d end wrap", lim), 32'(wrap_b), exp_wrap);
    cyc();
    check_val($sformatf("b l%0d idle busy", lim), 32'(busy_b), 32'd0);
    check_val($sformatf("b l%0d idle done", lim), 32'(done_b), 32'd0);
    check_val($sformatf("b l%0d idle cnt", lim),  32'(cnt_b), 32'(n_done % 16));
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0;
    div_val = 8'd0; limit_a = 16'd0; limit_b = 4'd0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_a_idle($sformatf("rst%0d", i), 0);
      check_val($sformatf("rst%0d wrap", i), 32'(wrap_a), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_a_idle($sformatf("idle%0d", i), 0);
    end
    // stop alone in IDLE does nothing
    stop_a = 1'b1;
    cyc();
    check_val("stop in idle busy", 32'(busy_a), 32'd0);
    stop_a = 1'b0;

    run_a(4, 17, 4, 1'b0, 1'b0);
    run_a(0, 5, 5, 1'b0, 1'b0);
    run_a(1, 5, 5, 1'b0, 1'b0);
    run_a(2, 6, 3, 1'b0, 1'b0);
    check_val("no wrap a", 32'(wrap_a), 32'd0);

    // start held through RUN and DONE: a new run starts only from IDLE
    run_a(3, 4, 1, 1'b1, 1'b0);
    cyc();
    check_val("held start rerun busy", 32'(busy_a), 32'd1);
    check_val("held start rerun cnt",  32'(cnt_a), 32'd0);
    start_a = 1'b0;
    stop_a  = 1'b1;
    cyc();
    check_val("held stop done", 32'(done_a), 32'd1);
    stop_a = 1'b0;
    cyc();
    check_val("held stop idle", 32'(busy_a), 32'd0);

    // start and stop together in IDLE: start wins
    run_a(2, 4, 2, 1'b0, 1'b1);

    run_b(3, 3, 0);
    run_b(0, 16, 1);

    // asynchronous reset mid-run after two ticks
    div_val = 8'd3;
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    repeat (6) cyc();
    check_val("pre-reset cnt", 32'(cnt_a), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async rst busy", 32'(busy_a), 32'd0);
    check_val("async rst cnt",  32'(cnt_a), 32'd0);
    check_val("async rst tick", 32'(tick_a), 32'd0);
    cyc();
    check_val("async rst no done", 32'(done_a), 32'd0);
    rst_n = 1'b1;
    cyc();
    run_a(3, 3, 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
